mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/mem_access_unit.sv | 216 +++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// -----------------------------------------------------------------------------
// mem_access_unit
//
// MEM-stage load/store unit. Turns an EX-stage request into one registered
// memory bus transaction and returns the sign- or zero-extended load result.
// The bus uses a request/acknowledge handshake with a bounded wait.
//
// Optional feature (compile-time macro):
//   MEM_ALIGN_CHECK_EN  defined   : a misaligned half or word access is
//                                   rejected with a one-cycle memFault and
//                                   no bus request.
//                       undefined : misaligned low address bits are forced to
//                                   the natural alignment and the access runs.
//
// Parameters:
//   TIMEOUT_CYCLES  maximum number of WAIT cycles for busAck (2..255)
//
// Ports:
//   clk, rst_n      clock; synchronous active-low reset
//   exValid         EX-stage instruction valid
//   exMemRead       load request
//   exMemWrite      store request (wins when both are set)
//   exMemSize       00 byte, 01 half, 10/11 word
//   exMemSigned     sign-extend byte/half loads when 1
//   exALUOut        effective address
//   exStoreData     store data (right-justified)
//   busReq/busWe    registered bus request and write enable
//   busAddr         word-aligned bus address
//   busWdata/busBe  lane-replicated write data and byte enables
//   busAck/busRdata bus completion and read data (valid with busAck)
//   memMemOut       load result (0 for stores, timeouts and faults)
//   memValid        one-cycle completion pulse
//   memFault        one-cycle timeout / alignment error pulse
//   memStall        combinational pipeline hold
// -----------------------------------------------------------------------------
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exValid,
  input  logic        exMemRead,
  input  logic        exMemWrite,
  input  logic [1:0]  exMemSize,
  input  logic        exMemSigned,
  input  logic [31:0] exALUOut,
  input  logic [31:0] exStoreData,
  output logic        busReq,
  output logic        busWe,
  output logic [31:0] busAddr,
  output logic [31:0] busWdata,
  output logic [3:0]  busBe,
  input  logic        busAck,
  input  logic [31:0] busRdata,
  output logic [31:0] memMemOut,
  output logic        memValid,
  output logic        memFault,
  output logic        memStall
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_e;
  typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_e;

  // Last WAIT cycle index; the counter starts at 0 on entry to WAIT.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_e      state_q;
  logic [7:0]  cnt_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [3:0]  bus_be_q;
  logic [31:0] mem_out_q;
  logic        mem_valid_q;
  logic        mem_fault_q;
  logic [1:0]  lane_q;     // byte offset of the access, used for extraction
  size_e       size_q;
  logic        signed_q;

  // Request decode (combinational)
  logic        req_present;
  logic        misaligned;
  size_e       req_size;
  logic [31:0] addr_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    req_present = exValid & (exMemRead | exMemWrite);
    req_size    = exMemSize[1] ? SZ_WORD : (exMemSize[0] ? SZ_HALF : SZ_BYTE);
    misaligned  = 1'b0;
    addr_d      = exALUOut;
`ifdef MEM_ALIGN_CHECK_EN
    misaligned  = ((req_size == SZ_HALF) && exALUOut[0]) ||
                  ((req_size == SZ_WORD) && (exALUOut[1:0] != 2'b00));
`else
    if (req_size == SZ_HALF) addr_d[0]   = 1'b0;
    if (req_size == SZ_WORD) addr_d[1:0] = 2'b00;
`endif
    be_d    = 4'b1111;
    wdata_d = exStoreData;
    case (req_size)
      SZ_BYTE: begin
        be_d    = 4'b0001 << addr_d[1:0];
        wdata_d = {4{exStoreData[7:0]}};
      end
      SZ_HALF: begin
        be_d    = 4'b0011 << addr_d[1:0];
        wdata_d = {2{exStoreData[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = exStoreData;
      end
    endcase
  end

  // Little-endian lane extraction of the returned read data
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data_d;

  always_comb begin
    case (lane_q)
      2'd0:    rd_byte = busRdata[7:0];
      2'd1:    rd_byte = busRdata[15:8];
      2'd2:    rd_byte = busRdata[23:16];
      default: rd_byte = busRdata[31:24];
    endcase
    rd_half = lane_q[1] ? busRdata[31:16] : busRdata[15:0];
    case (size_q)
      SZ_BYTE: load_data_d = signed_q ? {{24{rd_byte[7]}}, rd_byte}
                                      : {24'h0, rd_byte};
      SZ_HALF: load_data_d = signed_q ? {{16{rd_half[15]}}, rd_half}
                                      : {16'h0, rd_half};
      default: load_data_d = busRdata;
    endcase
  end

  // NOTE: all state below is updated with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 8'h0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'h0;
      bus_wdata_q <= 32'h0;
      bus_be_q    <= 4'h0;
      mem_out_q   <= 32'h0;
      mem_valid_q <= 1'b0;
      mem_fault_q <= 1'b0;
      lane_q      <= 2'd0;
      size_q      <= SZ_BYTE;
      signed_q    <= 1'b0;
    end else begin
      // Status outputs are single-cycle pulses unless re-asserted below.
      mem_valid_q <= 1'b0;
      mem_fault_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_present) begin
            if (misaligned) begin
              mem_fault_q <= 1'b1;
              mem_out_q   <= 32'h0;
            end else begin
              state_q     <= WAIT;
              cnt_q       <= 8'h0;
              bus_req_q   <= 1'b1;
              bus_we_q    <= exMemWrite;
              bus_addr_q  <= {addr_d[31:2], 2'b00};
              bus_be_q    <= be_d;
              bus_wdata_q <= wdata_d;
              lane_q      <= addr_d[1:0];
              size_q      <= req_size;
              signed_q    <= exMemSigned;
            end
          end
        end
        WAIT: begin
          // An acknowledge in the final allowed cycle still completes.
          if (busAck) begin
            state_q     <= DONE;
            bus_req_q   <= 1'b0;
            mem_out_q   <= bus_we_q ? 32'h0 : load_data_d;
            mem_valid_q <= 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            state_q     <= IDLE;
            bus_req_q   <= 1'b0;
            mem_out_q   <= 32'h0;
            mem_fault_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 8'h1;
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign memStall  = ((state_q == IDLE) && req_present) || (state_q == WAIT);
  assign busReq    = bus_req_q;
  assign busWe     = bus_we_q;
  assign busAddr   = bus_addr_q;
  assign busWdata  = bus_wdata_q;
  assign busBe     = bus_be_q;
  assign memMemOut = mem_out_q;
  assign memValid  = mem_valid_q;
  assign memFault  = mem_fault_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// -----------------------------------------------------------------------------
// tb_mem_access_unit
//
// Table of load/store transactions with expected bus fields and load results,
// plus hand-written sequences for timeout, reset mid-WAIT, ignored busAck,
// requests in DONE and the misaligned word load. Expected load results go to
// a scoreboard queue when the request is driven and are popped when memValid
// is seen. Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exValid, exMemRead, exMemWrite, exMemSigned;
  logic [1:0]  exMemSize;
  logic [31:0] exALUOut, exStoreData;
  logic        busReq, busWe, busAck;
  logic [31:0] busAddr, busWdata, busRdata;
  logic [3:0]  busBe;
  logic [31:0] memMemOut;
  logic        memValid, memFault, memStall;

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .exValid(exValid), .exMemRead(exMemRead), .exMemWrite(exMemWrite),
    .exMemSize(exMemSize), .exMemSigned(exMemSigned),
    .exALUOut(exALUOut), .exStoreData(exStoreData),
    .busReq(busReq), .busWe(busWe), .busAddr(busAddr),
    .busWdata(busWdata), .busBe(busBe),
    .busAck(busAck), .busRdata(busRdata),
    .memMemOut(memMemOut), .memValid(memValid),
    .memFault(memFault), .memStall(memStall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          delay;      // WAIT cycle in which busAck is raised (>=1)
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;  // checked for stores only
    logic        exp_we;
    logic [31:0] exp_out;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] sb_q[$];
  logic [31:0] last_out;
  int          n_vec  = 0;
  int          n_miss = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    exValid     = 1'b0;
    exMemRead   = 1'b0;
    exMemWrite  = 1'b0;
    exMemSize   = 2'b00;
    exMemSigned = 1'b0;
    exALUOut    = 32'h0;
    exStoreData = 32'h0;
  endtask

  task automatic drive_req(input vec_t v);
    exValid     = 1'b1;
    exMemRead   = v.rd;
    exMemWrite  = v.wr;
    exMemSize   = v.size;
    exMemSigned = v.sgn;
    exALUOut    = v.addr;
    exStoreData = v.wdata;
  endtask

  // One complete transaction; probe_done also offers a new request and a
  // stray busAck during DONE, both of which must be ignored.
  task automatic run_txn(input vec_t v, input bit probe_done);
    logic [31:0] exp;
    @(negedge clk);
    drive_req(v);
    #1 check("stall_in_request", memStall, 1);
    sb_q.push_back(v.exp_out);
    @(negedge clk);
    idle_inputs();
    check("busReq_asserted", busReq, 1);
    check("busWe", busWe, v.exp_we);
    check("busAddr", busAddr, v.exp_addr);
    check("busBe", busBe, v.exp_be);
    if (v.exp_we) check("busWdata", busWdata, v.exp_wdata);
    check("stall_in_wait", memStall, 1);
    for (int k = 1; k < v.delay; k++) begin
      @(negedge clk);
      check("busReq_hold", busReq, 1);
      check("busAddr_hold", busAddr, v.exp_addr);
      check("busBe_hold", busBe, v.exp_be);
    end
    busAck   = 1'b1;
    busRdata = v.rdata;
    @(negedge clk);
    busAck   = 1'b0;
    busRdata = 32'h5A5A_5A5A;
    check("memValid_done", memValid, 1);
    check("busReq_dropped", busReq, 0);
    check("stall_in_done", memStall, 0);
    exp = sb_q.pop_front();
    check("memMemOut", memMemOut, exp);
    last_out = exp;
    if (probe_done) begin
      exValid   = 1'b1;
      exMemRead = 1'b1;
      exALUOut  = 32'h0000_9000;
      busAck    = 1'b1;
      busRdata  = 32'hFFFF_FFFF;
      #1 check("stall_req_in_done", memStall, 0);
    end
    @(negedge clk);
    idle_inputs();
    busAck = 1'b0;
    check("memValid_single_pulse", memValid, 0);
    check("no_accept_in_done", busReq, 0);
    check("memMemOut_held", memMemOut, last_out);
  endtask

  initial begin
    vec_t v;
    idle_inputs();
    rst_n    = 1'b0;
    busAck   = 1'b0;
    busRdata = 32'h0;
    last_out = 32'h0;

    // rd wr size sgn addr wdata rdata delay | addr be wdata we out
    vecs.push_back('{1, 0, 2'b00, 1, 32'h0000_1003, 32'h0, 32'h80FF_0000, 2,
                     32'h0000_1000, 4'b1000, 32'h0, 0, 32'hFFFF_FF80});
    vecs.push_back('{0, 1, 2'b01, 0, 32'h0000_2002, 32'h0000_BEEF, 32'h0, 1,
                     32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 1, 32'h0});
    vecs.push_back('{1, 0, 2'b00, 0, 32'h0000_1001, 32'h0, 32'h1234_5678, 1,
                     32'h0000_1000, 4'b0010, 32'h0, 0, 32'h0000_0056});
    vecs.push_back('{1, 0, 2'b00, 1, 32'h0000_1002, 32'h0, 32'h12A4_5678, 3,
                     32'h0000_1000, 4'b0100, 32'h0, 0, 32'hFFFF_FFA4});
    vecs.push_back('{1, 0, 2'b01, 1, 32'h0000_4002, 32'h0, 32'h8001_7FFF, 1,
                     32'h0000_4000, 4'b1100, 32'h0, 0, 32'hFFFF_8001});
    vecs.push_back('{1, 0, 2'b01, 0, 32'h0000_4002, 32'h0, 32'h8001_7FFF, 1,
                     32'h0000_4000, 4'b1100, 32'h0, 0, 32'h0000_8001});
    vecs.push_back('{1, 0, 2'b01, 1, 32'h0000_4000, 32'h0, 32'h8001_7FFF, 2,
                     32'h0000_4000, 4'b0011, 32'h0, 0, 32'h0000_7FFF});
    vecs.push_back('{1, 0, 2'b10, 1, 32'h0000_5000, 32'h0, 32'hDEAD_BEEF, 1,
                     32'h0000_5000, 4'b1111, 32'h0, 0, 32'hDEAD_BEEF});
    vecs.push_back('{1, 0, 2'b11, 0, 32'h0000_5004, 32'h0, 32'h8765_4321, 2,
                     32'h0000_5004, 4'b1111, 32'h0, 0, 32'h8765_4321});
    vecs.push_back('{0, 1, 2'b00, 0, 32'h0000_6001, 32'h1234_56AB, 32'h0, 1,
                     32'h0000_6000, 4'b0010, 32'hABAB_ABAB, 1, 32'h0});
    vecs.push_back('{1, 1, 2'b10, 0, 32'h0000_7004, 32'hCAFE_F00D, 32'hFFFF_FFFF, 4,
                     32'h0000_7004, 4'b1111, 32'hCAFE_F00D, 1, 32'h0});

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busReq", busReq, 0);
    check("rst_busWe", busWe, 0);
    check("rst_busAddr", busAddr, 0);
    check("rst_busWdata", busWdata, 0);
    check("rst_busBe", busBe, 0);
    check("rst_memMemOut", memMemOut, 0);
    check("rst_memValid", memValid, 0);
    check("rst_memFault", memFault, 0);
    check("rst_memStall", memStall, 0);
    rst_n = 1'b1;

    // No request: valid without read/write, and read/write without valid
    @(negedge clk);
    exValid = 1'b1;
    #1 check("stall_no_rw", memStall, 0);
    @(negedge clk);
    check("busReq_no_rw", busReq, 0);
    exValid   = 1'b0;
    exMemRead = 1'b1;
    #1 check("stall_not_valid", memStall, 0);
    @(negedge clk);
    check("busReq_not_valid", busReq, 0);
    idle_inputs();

    for (int i = 0; i < vecs.size(); i++) run_txn(vecs[i], i == 1);

    // busAck while IDLE is ignored
    @(negedge clk);
    busAck   = 1'b1;
    busRdata = 32'h1357_9BDF;
    @(negedge clk);
    busAck = 1'b0;
    check("idle_ack_memValid", memValid, 0);
    check("idle_ack_memMemOut", memMemOut, last_out);

    // Misaligned word load at 0x3001
    v = '{1, 0, 2'b10, 0, 32'h0000_3001, 32'h0, 32'h0BAD_F00D, 1,
          32'h0000_3000, 4'b1111, 32'h0, 0, 32'h0BAD_F00D};
`ifdef MEM_ALIGN_CHECK_EN
    @(negedge clk);
    drive_req(v);
    #1 check("misalign_stall", memStall, 1);
    @(negedge clk);
    idle_inputs();
    check("misalign_no_busReq", busReq, 0);
    check("misalign_fault", memFault, 1);
    check("misalign_memMemOut", memMemOut, 0);
    check("misalign_stall_after", memStall, 0);
    @(negedge clk);
    check("misalign_fault_pulse", memFault, 0);
    last_out = 32'h0;
`else
    run_txn(v, 1'b0);
`endif

    // Timeout: word load, no busAck, TIMEOUT_CYCLES = 4
    v = '{1, 0, 2'b10, 0, 32'h0000_8000, 32'h0, 32'h0, 1,
          32'h0000_8000, 4'b1111, 32'h0, 0, 32'h0};
    @(negedge clk);
    drive_req(v);
    @(negedge clk);
    idle_inputs();
    for (int k = 1; k <= 4; k++) begin
      check("timeout_busReq_wait", busReq, 1);
      check("timeout_stall_wait", memStall, 1);
      check("timeout_no_fault_yet", memFault, 0);
      @(negedge clk);
    end
    check("timeout_busReq_dropped", busReq, 0);
    check("timeout_fault", memFault, 1);
    check("timeout_memMemOut", memMemOut, 0);
    check("timeout_memValid", memValid, 0);
    check("timeout_stall_idle", memStall, 0);
    busAck   = 1'b1;  // late acknowledge must be ignored
    busRdata = 32'h2468_ACE0;
    @(negedge clk);
    busAck = 1'b0;
    check("timeout_fault_pulse", memFault, 0);
    check("late_ack_memValid", memValid, 0);
    check("late_ack_busReq", busReq, 0);

    // Reset mid-WAIT after a completed load leaves memMemOut non-zero
    run_txn(vecs[0], 1'b0);
    v = vecs[7];
    @(negedge clk);
    drive_req(v);
    @(negedge clk);
    idle_inputs();
    check("rstwait_busReq_before", busReq, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("rstwait_busReq", busReq, 0);
    check("rstwait_busAddr", busAddr, 0);
    check("rstwait_busBe", busBe, 0);
    check("rstwait_memMemOut", memMemOut, 0);
    busAck   = 1'b1;
    busRdata = 32'h1111_1111;
    @(negedge clk);
    busAck = 1'b0;
    check("rstwait_ack_busReq", busReq, 0);
    check("rstwait_ack_memValid", memValid, 0);
    check("rstwait_ack_memMemOut", memMemOut, 0);
    @(negedge clk);
    check("rstwait_memValid_later", memValid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
